// File: rtl/pts_serializer.sv
// pts_serializer: parallel-to-serial front end for the 1101 sequence detector.
// Words arrive over a valid/ready handshake into a one-word holding register, then shift out one
// bit per shift_en cycle on serial_out. Back-to-back words stream with no idle gap.
// Optional feature: define PARITY_BIT_EN to append an even-parity bit after each word.
module pts_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StParity
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
`ifdef PARITY_BIT_EN
  logic              par_q, par_d;
`endif

  logic accept;    // handshake completes at the coming edge
  logic last_bit;  // last data bit consumed this cycle
  logic word_end;  // final bit of the word (data or parity) consumed this cycle
  logic reload;    // held word moves into the shifter at the coming edge
  logic cur_bit;

  // Handshake and word-boundary decode shared by the FSM and datapath
  always_comb begin
    accept   = load_valid && !hold_full_q;
    cur_bit  = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    last_bit = (state_q == StShift) && shift_en && (cnt_q == LastCnt);
`ifdef PARITY_BIT_EN
    word_end = (state_q == StParity) && shift_en;
`else
    word_end = last_bit;
`endif
    reload   = hold_full_q && ((state_q == StIdle) || word_end);
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (hold_full_q) state_d = StShift;
      end
      StShift: begin
        if (last_bit) begin
`ifdef PARITY_BIT_EN
          state_d = StParity;
`else
          state_d = hold_full_q ? StShift : StIdle;
`endif
        end
      end
`ifdef PARITY_BIT_EN
      StParity: begin
        if (shift_en) state_d = hold_full_q ? StShift : StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    serial_valid = 1'b0;
    serial_out   = 1'b0;
    unique case (state_q)
      StShift: begin
        serial_valid = 1'b1;
        serial_out   = cur_bit;
      end
`ifdef PARITY_BIT_EN
      StParity: begin
        serial_valid = 1'b1;
        serial_out   = par_q;
      end
`endif
      default: begin
        serial_valid = 1'b0;
        serial_out   = 1'b0;
      end
    endcase
    word_done  = word_end;
    load_ready = !hold_full_q;
    busy       = (state_q != StIdle) || hold_full_q;
  end

  // Holding register next state; accept and reload are mutually exclusive since ready = !full
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (accept) begin
      hold_d      = load_data;
      hold_full_d = 1'b1;
    end else if (reload) begin
      hold_full_d = 1'b0;
    end
  end

  // Shifter and bit counter next state
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
`ifdef PARITY_BIT_EN
    par_d   = par_q;
`endif
    if (reload) begin
      shift_d = hold_q;
      cnt_d   = '0;
`ifdef PARITY_BIT_EN
      par_d   = ^hold_q;
`endif
    end else if ((state_q == StShift) && shift_en) begin
      if (cnt_q != LastCnt) begin
        shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CntW'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Datapath registers; reset discards both the in-flight and the held word
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef PARITY_BIT_EN
  // Parity of the word currently in the shifter
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

endmodule
